// File: rtl/status_array_ctrl_if.sv
// Handshake and write-port bundle for the I-cache status array controller.
// Groups the fill/hit request channels, the array write port and init_done.
// Modports: master = requesters/array side, slave = status_array_ctrl.

interface status_array_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WAY_WIDTH  = 2,
    parameter int ROW_WIDTH  = 8,
    parameter int NUM_BLOCKS = 4
);

    logic                  i_fill_valid;
    logic                  o_fill_ready;
    logic [ADDR_WIDTH-1:0] i_fill_addr;
    logic [WAY_WIDTH-1:0]  i_fill_way;

    logic                  i_hit_valid;
    logic                  o_hit_ready;
    logic [ADDR_WIDTH-1:0] i_hit_addr;
    logic [WAY_WIDTH-1:0]  i_hit_way;
    logic [ROW_WIDTH-1:0]  i_hit_row;

    logic                  o_sa_w_valid;
    logic [ADDR_WIDTH-1:0] o_sa_w_addr;
    logic [ROW_WIDTH-1:0]  o_sa_w_data;
    logic [NUM_BLOCKS-1:0] o_sa_w_wmask;
    logic                  o_init_done;

    modport master (
        output i_fill_valid, i_fill_addr, i_fill_way,
        output i_hit_valid, i_hit_addr, i_hit_way, i_hit_row,
        input  o_fill_ready, o_hit_ready,
        input  o_sa_w_valid, o_sa_w_addr, o_sa_w_data, o_sa_w_wmask,
        input  o_init_done
    );

    modport slave (
        input  i_fill_valid, i_fill_addr, i_fill_way,
        input  i_hit_valid, i_hit_addr, i_hit_way, i_hit_row,
        output o_fill_ready, o_hit_ready,
        output o_sa_w_valid, o_sa_w_addr, o_sa_w_data, o_sa_w_wmask,
        output o_init_done
    );

endinterface

// File: rtl/status_array_ctrl.sv
// Write sequencer for the 16x8 I-cache status array: init/flush sweeps,
// fill updates and NRU hit updates onto the single registered write port.
// Ports: clk, arst_n (async active-low), i_halt, i_flush, bus (slave
// modport of status_array_ctrl_if). Optional STATUS_ARRAY_CTRL_STATS_EN
// adds o_stat_fills, o_stat_hits, o_stat_use_resets (16-bit saturating).

module status_array_ctrl #(
    parameter int NUM_ROWS    = 16,
    parameter int NUM_BLOCKS  = 4,
    parameter int BLOCK_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 i_halt,
    input  logic                 i_flush,
    status_array_ctrl_if.slave   bus
`ifdef STATUS_ARRAY_CTRL_STATS_EN
    ,
    output logic [15:0]          o_stat_fills,
    output logic [15:0]          o_stat_hits,
    output logic [15:0]          o_stat_use_resets
`endif
);

    localparam int ADDR_WIDTH = $clog2(NUM_ROWS);
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int ROW_WIDTH  = NUM_BLOCKS * BLOCK_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  w_valid_q, w_valid_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ROW_WIDTH-1:0]  w_data_q, w_data_d;
    logic [NUM_BLOCKS-1:0] w_wmask_q, w_wmask_d;
    logic                  init_done_q, init_done_d;

    logic                  fill_ready;
    logic                  hit_ready;
    logic                  addr_busy;
    logic                  fill_acc;
    logic                  hit_acc;

    logic [NUM_BLOCKS-1:0] fill_sel;
    logic [ROW_WIDTH-1:0]  fill_data;

    logic [NUM_BLOCKS-1:0] hit_sel;
    logic [NUM_BLOCKS-1:0] hit_use;
    logic [NUM_BLOCKS-1:0] hit_vld;
    logic                  hit_sat;
    logic [ROW_WIDTH-1:0]  hit_data_one;
    logic [ROW_WIDTH-1:0]  hit_data_sat;

    // A request seen with flush would never be written, so the readies
    // drop with it to keep the handshake honest.
    always_comb begin
        fill_ready = (state_q == ST_RUN) & ~i_halt & ~i_flush;
        // The row being written this cycle is stale in i_hit_row.
        addr_busy  = w_valid_q & (w_addr_q == bus.i_hit_addr);
        hit_ready  = fill_ready & ~bus.i_fill_valid & ~addr_busy;
        fill_acc   = fill_ready & bus.i_fill_valid;
        hit_acc    = hit_ready & bus.i_hit_valid;
    end

    assign bus.o_fill_ready = fill_ready;
    assign bus.o_hit_ready  = hit_ready;

    always_comb begin
        fill_sel  = '0;
        fill_sel[bus.i_fill_way] = 1'b1;
        fill_data = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (fill_sel[b]) begin
                fill_data[b*BLOCK_WIDTH]   = 1'b1;
                fill_data[b*BLOCK_WIDTH+1] = 1'b1;
            end
        end
    end

    // NRU: the hit way's use bit is set; if that leaves every valid way
    // used, all other use bits are cleared in one full-row write.
    always_comb begin
        hit_sel = '0;
        hit_sel[bus.i_hit_way] = 1'b1;
        hit_use = '0;
        hit_vld = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            hit_use[b] = bus.i_hit_row[b*BLOCK_WIDTH];
            hit_vld[b] = bus.i_hit_row[b*BLOCK_WIDTH+1];
        end
        // Invalid ways never block saturation.
        hit_sat = &(hit_use | hit_sel | ~hit_vld);
        hit_data_one = '0;
        hit_data_sat = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            hit_data_sat[b*BLOCK_WIDTH]   = hit_sel[b];
            hit_data_sat[b*BLOCK_WIDTH+1] = hit_vld[b];
            if (hit_sel[b]) begin
                hit_data_one[b*BLOCK_WIDTH]   = 1'b1;
                hit_data_one[b*BLOCK_WIDTH+1] = hit_vld[b];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_valid_d   = w_valid_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        w_wmask_d   = w_wmask_q;
        init_done_d = init_done_q;
        // Halt freezes everything so a presented write stays on the
        // gated array port until it can commit.
        if (!i_halt) begin
            if (i_flush) begin
                state_d     = ST_INIT;
                cnt_d       = '0;
                w_valid_d   = 1'b0;
                init_done_d = 1'b0;
            end else begin
                unique case (state_q)
                    ST_INIT: begin
                        if (cnt_q < CNT_WIDTH'(NUM_ROWS)) begin
                            w_valid_d = 1'b1;
                            w_addr_d  = cnt_q[ADDR_WIDTH-1:0];
                            w_data_d  = '0;
                            w_wmask_d = '1;
                            cnt_d     = cnt_q + CNT_WIDTH'(1);
                        end else begin
                            w_valid_d   = 1'b0;
                            init_done_d = 1'b1;
                            state_d     = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        w_valid_d = fill_acc | hit_acc;
                        unique case (1'b1)
                            fill_acc: begin
                                w_addr_d  = bus.i_fill_addr;
                                w_data_d  = fill_data;
                                w_wmask_d = fill_sel;
                            end
                            hit_acc: begin
                                w_addr_d  = bus.i_hit_addr;
                                w_data_d  = hit_sat ? hit_data_sat
                                                    : hit_data_one;
                                w_wmask_d = hit_sat ? '1 : hit_sel;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            w_valid_q   <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            w_wmask_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_valid_q   <= w_valid_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            w_wmask_q   <= w_wmask_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.o_sa_w_valid = w_valid_q;
    assign bus.o_sa_w_addr  = w_addr_q;
    assign bus.o_sa_w_data  = w_data_q;
    assign bus.o_sa_w_wmask = w_wmask_q;
    assign bus.o_init_done  = init_done_q;

`ifdef STATUS_ARRAY_CTRL_STATS_EN
    logic [15:0] st_fill_q, st_fill_d;
    logic [15:0] st_hit_q, st_hit_d;
    logic [15:0] st_ures_q, st_ures_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    always_comb begin
        st_fill_d = st_fill_q;
        st_hit_d  = st_hit_q;
        st_ures_d = st_ures_q;
        if (!i_halt) begin
            if (i_flush) begin
                st_fill_d = '0;
                st_hit_d  = '0;
                st_ures_d = '0;
            end else begin
                if (fill_acc) st_fill_d = sat_inc(st_fill_q);
                if (hit_acc) st_hit_d = sat_inc(st_hit_q);
                if (hit_acc && hit_sat) st_ures_d = sat_inc(st_ures_q);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st_fill_q <= '0;
            st_hit_q  <= '0;
            st_ures_q <= '0;
        end else begin
            st_fill_q <= st_fill_d;
            st_hit_q  <= st_hit_d;
            st_ures_q <= st_ures_d;
        end
    end

    assign o_stat_fills      = st_fill_q;
    assign o_stat_hits       = st_hit_q;
    assign o_stat_use_resets = st_ures_q;
`endif

endmodule

// File: tb/tb_status_array_ctrl.sv
// Self-checking bench for status_array_ctrl: reset sweep, vector table,
// directed corner sequences and random traffic against a reference model.

module tb_status_array_ctrl;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic halt = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    status_array_ctrl_if bus ();

`ifdef STATUS_ARRAY_CTRL_STATS_EN
    logic [15:0] st_f, st_h, st_u;
`endif

    status_array_ctrl dut (
        .clk    (clk),
        .arst_n (arst_n),
        .i_halt (halt),
        .i_flush(flush),
        .bus    (bus)
`ifdef STATUS_ARRAY_CTRL_STATS_EN
        ,
        .o_stat_fills     (st_f),
        .o_stat_hits      (st_h),
        .o_stat_use_resets(st_u)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: sweep position, expected registered write port.
    bit         m_run;
    int         m_pos;
    bit         m_wv;
    logic [3:0] m_wa;
    logic [7:0] m_wd;
    logic [3:0] m_wm;
    bit         m_done;
    int         m_sf, m_sh, m_su;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_wv = 0; m_done = 0;
        m_wa = '0; m_wd = '0; m_wm = '0;
        m_sf = 0; m_sh = 0; m_su = 0;
    endtask

    function automatic void nru(input logic [7:0] row, input int way,
                                output logic [7:0] d,
                                output logic [3:0] m, output bit sat);
        int unused_ways = 0;
        for (int w = 0; w < 4; w++)
            if (row[2*w+1] && !row[2*w] && w != way) unused_ways++;
        sat = (unused_ways == 0);
        d = '0;
        if (!sat) begin
            m = 4'(1 << way);
            d[2*way+1] = row[2*way+1];
            d[2*way]   = 1'b1;
        end else begin
            m = 4'hF;
            for (int w = 0; w < 4; w++) begin
                d[2*w+1] = row[2*w+1];
                d[2*w]   = (w == way);
            end
        end
    endfunction

    task automatic set_in(input bit fv, input logic [3:0] fa,
                          input logic [1:0] fw, input bit hv,
                          input logic [3:0] ha, input logic [1:0] hw,
                          input logic [7:0] hr);
        bus.i_fill_valid = fv; bus.i_fill_addr = fa; bus.i_fill_way = fw;
        bus.i_hit_valid = hv; bus.i_hit_addr = ha; bus.i_hit_way = hw;
        bus.i_hit_row = hr;
    endtask

    task automatic idle_in();
        set_in(0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 8'h00);
    endtask

    // Called at a falling edge with inputs already driven; returns at
    // the next falling edge after checking readies and the new outputs.
    task automatic cycle();
        bit efr, ehr, af, ah, sat;
        logic [7:0] d;
        logic [3:0] m;
        #1;
        efr = m_run && !halt && !flush;
        ehr = efr && !bus.i_fill_valid &&
              !(m_wv && m_wa == bus.i_hit_addr);
        chk("fill_ready", bus.o_fill_ready, efr);
        chk("hit_ready", bus.o_hit_ready, ehr);
        af = efr && bus.i_fill_valid;
        ah = ehr && bus.i_hit_valid;
        @(posedge clk);
        if (!halt) begin
            if (flush) begin
                m_run = 0; m_pos = 0; m_wv = 0; m_done = 0;
                m_sf = 0; m_sh = 0; m_su = 0;
            end else if (!m_run) begin
                if (m_pos < 16) begin
                    m_wv = 1; m_wa = 4'(m_pos); m_wd = 8'h00;
                    m_wm = 4'hF; m_pos++;
                end else begin
                    m_wv = 0; m_done = 1; m_run = 1;
                end
            end else if (af) begin
                m_wv = 1; m_wa = bus.i_fill_addr;
                m_wm = 4'(1 << bus.i_fill_way);
                m_wd = 8'h00;
                m_wd[2*bus.i_fill_way]   = 1'b1;
                m_wd[2*bus.i_fill_way+1] = 1'b1;
                if (m_sf < 65535) m_sf++;
            end else if (ah) begin
                nru(bus.i_hit_row, int'(bus.i_hit_way), d, m, sat);
                m_wv = 1; m_wa = bus.i_hit_addr; m_wd = d; m_wm = m;
                if (m_sh < 65535) m_sh++;
                if (sat && m_su < 65535) m_su++;
            end else begin
                m_wv = 0;
            end
        end
        #1;
        chk("w_valid", bus.o_sa_w_valid, m_wv);
        chk("init_done", bus.o_init_done, m_done);
        if (m_wv) begin
            chk("w_addr", bus.o_sa_w_addr, m_wa);
            chk("w_data", bus.o_sa_w_data, m_wd);
            chk("w_wmask", bus.o_sa_w_wmask, m_wm);
        end
`ifdef STATUS_ARRAY_CTRL_STATS_EN
        chk("stat_fills", st_f, m_sf);
        chk("stat_hits", st_h, m_sh);
        chk("stat_use_resets", st_u, m_su);
`endif
        @(negedge clk);
    endtask

    typedef struct {
        bit         fv;
        logic [3:0] fa;
        logic [1:0] fw;
        bit         hv;
        logic [3:0] ha;
        logic [1:0] hw;
        logic [7:0] hr;
        bit         ev;
        logic [3:0] ea;
        logic [7:0] ed;
        logic [3:0] em;
    } vec_t;

    vec_t vt[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1, 4'd5,  2'd2, 0, 4'd0, 2'd0, 8'h00, 1, 4'd5,  8'h30, 4'b0100};
        vt[1] = '{0, 4'd0,  2'd0, 1, 4'd3, 2'd1, 8'hFB, 1, 4'd3,  8'hAE, 4'hF};
        vt[2] = '{0, 4'd0,  2'd0, 1, 4'd9, 2'd0, 8'hFF, 1, 4'd9,  8'hAB, 4'hF};
        vt[3] = '{0, 4'd0,  2'd0, 1, 4'd2, 2'd3, 8'h00, 1, 4'd2,  8'h40, 4'hF};
        vt[4] = '{0, 4'd0,  2'd0, 1, 4'd7, 2'd2, 8'hAA, 1, 4'd7,  8'h30, 4'b0100};
        vt[5] = '{0, 4'd0,  2'd0, 1, 4'd4, 2'd0, 8'h0D, 1, 4'd4,  8'h09, 4'hF};
        vt[6] = '{0, 4'd0,  2'd0, 1, 4'd6, 2'd1, 8'hC2, 1, 4'd6,  8'h04, 4'b0010};
        vt[7] = '{1, 4'd15, 2'd0, 0, 4'd0, 2'd0, 8'h00, 1, 4'd15, 8'h03, 4'b0001};
        vt[8] = '{1, 4'd1,  2'd3, 1, 4'd8, 2'd0, 8'hFF, 1, 4'd1,  8'hC0, 4'b1000};
        vt[9] = '{0, 4'd0,  2'd0, 0, 4'd0, 2'd0, 8'h00, 0, 4'd0,  8'h00, 4'h0};

        idle_in();
        model_reset();
        #2;
        chk("rst w_valid", bus.o_sa_w_valid, 0);
        chk("rst w_addr", bus.o_sa_w_addr, 0);
        chk("rst w_data", bus.o_sa_w_data, 0);
        chk("rst w_wmask", bus.o_sa_w_wmask, 0);
        chk("rst init_done", bus.o_init_done, 0);
        chk("rst fill_ready", bus.o_fill_ready, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // Power-up sweep
        for (int i = 0; i < 17; i++) begin
            cycle();
            if (i < 16) begin
                chk("sweep addr", bus.o_sa_w_addr, i);
                chk("sweep wmask", bus.o_sa_w_wmask, 4'hF);
                chk("sweep done low", bus.o_init_done, 0);
            end else begin
                chk("sweep done", bus.o_init_done, 1);
                chk("sweep end valid", bus.o_sa_w_valid, 0);
            end
        end

        // Vector table, one idle cycle between entries
        for (int i = 0; i < 10; i++) begin
            set_in(vt[i].fv, vt[i].fa, vt[i].fw, vt[i].hv,
                   vt[i].ha, vt[i].hw, vt[i].hr);
            cycle();
            chk("vec valid", bus.o_sa_w_valid, vt[i].ev);
            if (vt[i].ev) begin
                chk("vec addr", bus.o_sa_w_addr, vt[i].ea);
                chk("vec data", bus.o_sa_w_data, vt[i].ed);
                chk("vec wmask", bus.o_sa_w_wmask, vt[i].em);
            end
            idle_in();
            cycle();
        end

        // Fill and hit together, different rows: hit goes next cycle
        set_in(1, 4'd1, 2'd0, 1, 4'd2, 2'd1, 8'hFF);
        cycle();
        chk("fh diff fill addr", bus.o_sa_w_addr, 4'd1);
        set_in(0, 4'd0, 2'd0, 1, 4'd2, 2'd1, 8'hFF);
        cycle();
        chk("fh diff hit valid", bus.o_sa_w_valid, 1);
        chk("fh diff hit addr", bus.o_sa_w_addr, 4'd2);
        idle_in();
        cycle();

        // Same row: hit waits for the fill write to leave the port
        set_in(1, 4'd6, 2'd1, 1, 4'd6, 2'd2, 8'h00);
        cycle();
        chk("fh same fill addr", bus.o_sa_w_addr, 4'd6);
        set_in(0, 4'd0, 2'd0, 1, 4'd6, 2'd2, 8'h0C);
        cycle();
        chk("fh same stall", bus.o_sa_w_valid, 0);
        cycle();
        chk("fh same hit valid", bus.o_sa_w_valid, 1);
        chk("fh same hit wmask", bus.o_sa_w_wmask, 4'hF);
        idle_in();
        cycle();

        // Flush in RUN with a pending fill
        flush = 1'b1;
        set_in(1, 4'd9, 2'd3, 0, 4'd0, 2'd0, 8'h00);
        cycle();
        flush = 1'b0;
        chk("flush done low", bus.o_init_done, 0);
        chk("flush no write", bus.o_sa_w_valid, 0);
        for (int i = 0; i < 17; i++) begin
            cycle();
            if (i < 16) begin
                chk("flush sweep addr", bus.o_sa_w_addr, i);
                chk("flush done held", bus.o_init_done, 0);
            end else begin
                chk("flush done back", bus.o_init_done, 1);
            end
        end
        cycle();
        chk("flush fill valid", bus.o_sa_w_valid, 1);
        chk("flush fill addr", bus.o_sa_w_addr, 4'd9);
        chk("flush fill wmask", bus.o_sa_w_wmask, 4'b1000);
        idle_in();
        cycle();

        // Async reset mid-sweep, then halt at row 7
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        chk("arst w_valid", bus.o_sa_w_valid, 0);
        chk("arst w_addr", bus.o_sa_w_addr, 0);
        chk("arst done", bus.o_init_done, 0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("halt pre addr", bus.o_sa_w_addr, 4'd7);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("halt hold addr", bus.o_sa_w_addr, 4'd7);
            chk("halt hold valid", bus.o_sa_w_valid, 1);
        end
        halt = 1'b0;
        for (int i = 8; i < 16; i++) begin
            cycle();
            chk("halt resume addr", bus.o_sa_w_addr, i);
            chk("halt done low", bus.o_init_done, 0);
        end
        cycle();
        chk("halt done late", bus.o_init_done, 1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            halt  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 79) == 0);
            set_in($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   8'($urandom));
            cycle();
        end
        halt = 1'b0;
        flush = 1'b0;
        idle_in();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
